// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access unit: funct3 size codes,
// FSM state encoding and the default timeout.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int DEF_TIMEOUT_CYC = 255;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load result shaping: picks the addressed byte/half out of a bus word and
// sign- or zero-extends it according to funct3.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    ext = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    ext = {{16{half_sel[15]}}, half_sel};
      F3_BU:   ext = {24'd0, byte_sel};
      F3_HU:   ext = {16'd0, half_sel};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access unit: validates a decoded load/store, runs one bus
// transaction over a valid/ready bus, stalls the core meanwhile and returns
// extended load data.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        rd_valid,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        m_req_valid,
  input  logic        m_req_ready,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_rsp_valid,
  input  logic [31:0] m_rdata,
  output mem_state_t  dbg_state
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYC);

  mem_state_t    state_q, state_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [2:0]    f3_q, f3_d;
  logic [31:0]   word_q, word_d;
  logic          flt_q, flt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        access, illegal, f3_ok, aligned, go;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;

  always_comb begin
    access  = mem_read ^ mem_write;
    illegal = mem_read & mem_write;
    if (mem_read) f3_ok = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    else          f3_ok = funct3 inside {F3_B, F3_H, F3_W};
    case (funct3)
      F3_H, F3_HU: aligned = ~addr[0];
      F3_W:        aligned = (addr[1:0] == 2'b00);
      default:     aligned = 1'b1;
    endcase
    go = access & f3_ok & aligned;

    // Stores replicate the datum across lanes and let the strobe pick the bytes.
    lane_wdata = 32'd0;
    lane_wstrb = 4'b0000;
    if (mem_write) begin
      case (funct3)
        F3_B: begin
          lane_wdata = {4{wdata[7:0]}};
          lane_wstrb = 4'b0001 << addr[1:0];
        end
        F3_H: begin
          lane_wdata = {2{wdata[15:0]}};
          lane_wstrb = addr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          lane_wdata = wdata;
          lane_wstrb = 4'b1111;
        end
      endcase
    end
  end

  // Bus handshake: a request transfers on a cycle with m_req_valid & m_req_ready;
  // the payload is held stable from latched state until then. The response
  // (read data or write ack) is one m_rsp_valid cycle, only honoured in WAIT.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    f3_d        = f3_q;
    word_d      = word_q;
    flt_d       = flt_q;
    cnt_d       = cnt_q;
    stall       = 1'b0;
    fault       = 1'b0;
    rd_valid    = 1'b0;
    m_req_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          stall   = 1'b1;
          state_d = S_REQ;
          we_d    = mem_write;
          addr_d  = addr;
          wdata_d = lane_wdata;
          wstrb_d = lane_wstrb;
          f3_d    = funct3;
          flt_d   = 1'b0;
          cnt_d   = '0;
        end else if (illegal | access) begin
          fault = 1'b1;
        end
      end
      S_REQ: begin
        stall       = 1'b1;
        m_req_valid = 1'b1;
        if (m_req_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (m_rsp_valid) begin
          word_d  = m_rdata;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == TO_LIM) begin
            state_d = S_DONE;
            flt_d   = 1'b1;
            word_d  = 32'd0;
          end
        end
      end
      S_DONE: begin
        rd_valid = ~we_q & ~flt_q;
        fault    = flt_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'b0000;
      f3_q    <= 3'b000;
      word_q  <= 32'd0;
      flt_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      f3_q    <= f3_d;
      word_q  <= word_d;
      flt_q   <= flt_d;
      cnt_q   <= cnt_d;
    end
  end

  load_extend u_load_extend (
    .word    (word_q),
    .addr_lo (addr_q[1:0]),
    .funct3  (f3_q),
    .ext     (rdata)
  );

  assign m_we      = we_q;
  assign m_addr    = {addr_q[31:2], 2'b00};
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a reactive bus model, driver tasks that
// push expected bus requests/responses, and a monitor that pops and compares.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic        stall, rd_valid, fault, m_req_valid, m_we;
  logic [31:0] rdata, m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_req_ready = 1'b0, m_rsp_valid = 1'b0;
  logic [31:0] m_rdata = 32'd0;
  mem_state_t  dbg_state;

  mem_access_unit #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall),
    .rd_valid(rd_valid), .rdata(rdata), .fault(fault),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_we(m_we),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rsp_valid(m_rsp_valid), .m_rdata(m_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [69:0] exp_req_q[$];  // {chk_wdata, we, addr, wdata, wstrb}
  logic [34:0] exp_rsp_q[$];  // {chk_data, rd_valid, fault, rdata}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, wanted %h", name, act, exp);
    end
  endtask

  task automatic push_req(input logic cw, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] st);
    exp_req_q.push_back({cw, we, a, wd, st});
  endtask

  task automatic push_rsp(input logic cd, input logic rv, input logic f, input logic [31:0] d);
    exp_rsp_q.push_back({cd, rv, f, d});
  endtask

  // ---------------- bus model ----------------
  int          bus_rdy_wait = 0, bus_rsp_wait = 0;
  logic        bus_rsp_en = 1'b1;
  logic [31:0] bus_word = 32'd0;
  int          req_cnt = 0, rsp_cnt = 0;
  logic        wait_phase = 1'b0;

  always @(negedge clk) begin
    m_req_ready = 1'b0;
    m_rsp_valid = 1'b0;
    if (m_req_valid) begin
      if (req_cnt >= bus_rdy_wait) begin
        m_req_ready = 1'b1;
        wait_phase  = 1'b1;
        req_cnt     = 0;
        rsp_cnt     = 0;
      end else begin
        req_cnt++;
      end
    end else if (wait_phase && bus_rsp_en) begin
      if (rsp_cnt >= bus_rsp_wait) begin
        m_rsp_valid = 1'b1;
        m_rdata     = bus_word;
        wait_phase  = 1'b0;
      end else begin
        rsp_cnt++;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [69:0] cur_req = '0;
  logic        cur_ok = 1'b0;
  logic        req_prev = 1'b0;
  logic [34:0] e_rsp;

  always @(negedge clk) begin
    if (!rst_n) begin
      req_prev = 1'b0;
    end else begin
      if (m_req_valid) begin
        if (!req_prev) begin
          if (exp_req_q.size() == 0) begin
            n_tests++;
            n_fail++;
            cur_ok = 1'b0;
            $display("FAIL unexpected_req: got request addr=%h we=%b, wanted none", m_addr, m_we);
          end else begin
            cur_req = exp_req_q.pop_front();
            cur_ok  = 1'b1;
          end
        end
        if (cur_ok) begin
          chk("req_we", m_we, cur_req[68]);
          chk("req_addr", m_addr, cur_req[67:36]);
          chk("req_wstrb", m_wstrb, cur_req[3:0]);
          if (cur_req[69]) chk("req_wdata", m_wdata, cur_req[35:4]);
        end
      end
      req_prev = m_req_valid;

      if (rd_valid || fault) begin
        if (exp_rsp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rd_valid=%b fault=%b rdata=%h, wanted none",
                   rd_valid, fault, rdata);
        end else begin
          e_rsp = exp_rsp_q.pop_front();
          chk("rsp_rd_valid", rd_valid, e_rsp[33]);
          chk("rsp_fault", fault, e_rsp[32]);
          if (e_rsp[34]) chk("rsp_rdata", rdata, e_rsp[31:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input int rdy_w,
                     input int rsp_w, input logic rsp_en, input logic [31:0] word,
                     input int exp_stall);
    int stalls = 0;
    bit done = 0;
    @(posedge clk); #1;
    bus_rdy_wait = rdy_w;
    bus_rsp_wait = rsp_w;
    bus_rsp_en   = rsp_en;
    bus_word     = word;
    req_cnt      = 0;
    wait_phase   = 1'b0;
    mem_read  = rd;
    mem_write = wr;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1;
        break;
      end
      stalls++;
    end
    chk({name, "_completes"}, 32'(done), 32'd1);
    chk({name, "_stalls"}, stalls, exp_stall);
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_stall"}, stall, 1'b0);
    chk({tag, "_rd_valid"}, rd_valid, 1'b0);
    chk({tag, "_fault"}, fault, 1'b0);
    chk({tag, "_req_valid"}, m_req_valid, 1'b0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit got;
    #2;
    chk_quiet("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // lw, zero-wait
    push_req(1'b0, 1'b0, 32'h100, 32'd0, 4'b0000);
    push_rsp(1'b1, 1'b1, 1'b0, 32'hDEADBEEF);
    run("lw_100", 1, 0, F3_W, 32'h100, 32'd0, 0, 0, 1'b1, 32'hDEADBEEF, 3);

    // byte/half extraction with sign and zero extension
    push_req(1'b0, 1'b0, 32'h100, 32'd0, 4'b0000);
    push_rsp(1'b1, 1'b1, 1'b0, 32'hFFFFFF80);
    run("lb_103", 1, 0, F3_B, 32'h103, 32'd0, 0, 0, 1'b1, 32'h80FF1234, 3);
    push_req(1'b0, 1'b0, 32'h100, 32'd0, 4'b0000);
    push_rsp(1'b1, 1'b1, 1'b0, 32'h00000080);
    run("lbu_103", 1, 0, F3_BU, 32'h103, 32'd0, 0, 0, 1'b1, 32'h80FF1234, 3);
    push_req(1'b0, 1'b0, 32'h100, 32'd0, 4'b0000);
    push_rsp(1'b1, 1'b1, 1'b0, 32'hFFFF80FF);
    run("lh_102", 1, 0, F3_H, 32'h102, 32'd0, 0, 0, 1'b1, 32'h80FF1234, 3);
    push_req(1'b0, 1'b0, 32'h100, 32'd0, 4'b0000);
    push_rsp(1'b1, 1'b1, 1'b0, 32'h00001234);
    run("lhu_100", 1, 0, F3_HU, 32'h100, 32'd0, 0, 0, 1'b1, 32'h80FF1234, 3);

    // stores: lane placement, ready back-pressure, late ack
    push_req(1'b1, 1'b1, 32'h100, 32'hABCDABCD, 4'b1100);
    run("sh_102", 0, 1, F3_H, 32'h102, 32'h0000ABCD, 2, 0, 1'b1, 32'd0, 5);
    push_req(1'b1, 1'b1, 32'h100, 32'h77777777, 4'b0010);
    run("sb_101", 0, 1, F3_B, 32'h101, 32'h12345677, 0, 1, 1'b1, 32'd0, 4);
    push_req(1'b1, 1'b1, 32'h104, 32'hCAFEF00D, 4'b1111);
    run("sw_104", 0, 1, F3_W, 32'h104, 32'hCAFEF00D, 0, 0, 1'b1, 32'd0, 3);

    // rejected in IDLE: one-cycle fault, no stall, no bus request
    push_rsp(1'b0, 1'b0, 1'b1, 32'd0);
    run("lw_misaligned", 1, 0, F3_W, 32'h102, 32'd0, 0, 0, 1'b1, 32'd0, 0);
    push_rsp(1'b0, 1'b0, 1'b1, 32'd0);
    run("rd_and_wr", 1, 1, F3_W, 32'h100, 32'd0, 0, 0, 1'b1, 32'd0, 0);
    push_rsp(1'b0, 1'b0, 1'b1, 32'd0);
    run("lh_misaligned", 1, 0, F3_H, 32'h101, 32'd0, 0, 0, 1'b1, 32'd0, 0);
    push_rsp(1'b0, 1'b0, 1'b1, 32'd0);
    run("load_bad_f3", 1, 0, 3'b011, 32'h100, 32'd0, 0, 0, 1'b1, 32'd0, 0);
    push_rsp(1'b0, 1'b0, 1'b1, 32'd0);
    run("store_bad_f3", 0, 1, F3_BU, 32'h100, 32'd0, 0, 0, 1'b1, 32'd0, 0);

    // timeout: no response ever arrives
    push_req(1'b0, 1'b0, 32'h010, 32'd0, 4'b0000);
    push_rsp(1'b1, 1'b0, 1'b1, 32'd0);
    run("lw_timeout", 1, 0, F3_W, 32'h010, 32'd0, 0, 0, 1'b0, 32'h55AA55AA, 2 + TO);

    // reset while waiting, then a stale response
    push_req(1'b0, 1'b0, 32'h200, 32'd0, 4'b0000);
    @(posedge clk); #1;
    bus_rdy_wait = 0;
    bus_rsp_en   = 1'b0;
    bus_word     = 32'h87654321;
    req_cnt      = 0;
    wait_phase   = 1'b0;
    mem_read = 1'b1;
    funct3   = F3_W;
    addr     = 32'h200;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dbg_state == S_WAIT) begin
        got = 1;
        break;
      end
    end
    chk("rst_reach_wait", 32'(got), 32'd1);
    #2;
    rst_n    = 1'b0;
    mem_read = 1'b0;
    #1;
    chk_quiet("midrst");
    @(posedge clk); #1;
    rst_n      = 1'b1;
    bus_rsp_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_rd_valid", rd_valid, 1'b0);
      chk("late_state", 32'(dbg_state), 32'(S_IDLE));
    end

    // normal operation after reset
    push_req(1'b0, 1'b0, 32'h300, 32'd0, 4'b0000);
    push_rsp(1'b1, 1'b1, 1'b0, 32'h13579BDF);
    run("lw_after_rst", 1, 0, F3_W, 32'h300, 32'd0, 0, 0, 1'b1, 32'h13579BDF, 3);

    // ---------------- report ----------------
    repeat (5) @(posedge clk);
    chk("req_queue_drained", exp_req_q.size(), 32'd0);
    chk("rsp_queue_drained", exp_rsp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
